// File: rtl/raster_pkg.sv
// Shared types for the raster pattern generator.
//   mode_e  : pattern select values as presented on the mode input.
//   state_e : scan controller states.
package raster_pkg;

  typedef enum logic [1:0] {
    MODE_FILL    = 2'd0,
    MODE_HGRAD   = 2'd1,
    MODE_VGRAD   = 2'd2,
    MODE_CHECKER = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/raster_pattern_gen_if.sv
// Pixel stream between the generator (master) and a sink (slave).
//   pix_valid : x, y, pixel, border hold a valid pixel (master -> slave)
//   pix_ready : sink accepts the current pixel         (slave -> master)
//   x, y      : pixel coordinate
//   pixel     : grayscale value
//   border    : pixel lies on the window edge
interface raster_pattern_gen_if #(
  parameter int COORD_W = 11,
  parameter int PIX_W   = 8
);
  logic               pix_valid;
  logic               pix_ready;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [PIX_W-1:0]   pixel;
  logic               border;

  modport master (output pix_valid, x, y, pixel, border, input pix_ready);
  modport slave  (input pix_valid, x, y, pixel, border, output pix_ready);
endinterface

// File: rtl/raster_xy_counter.sv
// Raster-order coordinate stepper.
//   clock, reset_n : clock, asynchronous active-low reset
//   enable         : advance one pixel (x first, then y)
//   clear          : force x = y = 0 (wins over enable)
//   w, h           : window size (non-zero while stepping)
//   x, y           : current coordinate
//   last           : current coordinate is the final pixel of the window
module raster_xy_counter #(
  parameter int COORD_W = 11
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               clear,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  logic [COORD_W-1:0] w_max;
  logic [COORD_W-1:0] h_max;

  assign w_max = w - COORD_W'(1);
  assign h_max = h - COORD_W'(1);
  assign last  = (x == w_max) && (y == h_max);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (enable) begin
      if (x != w_max) begin
        x <= x + COORD_W'(1);
      end else begin
        x <= '0;
        // Wrapping at the final pixel leaves the counter parked at the origin.
        y <= (y != h_max) ? y + COORD_W'(1) : '0;
      end
    end
  end

endmodule

// File: rtl/raster_pattern_gen.sv
// Raster test-pattern generator: on an accepted start it latches the window
// and pattern config and streams W*H pixels in raster order over a
// valid/ready interface, then pulses done for one cycle.
//   clock, reset_n        : clock, asynchronous active-low reset
//   start                 : one-cycle frame trigger
//   win_w, win_h          : window size, sampled at accepted start
//   mode, fill, border_en : pattern config, sampled at accepted start
//   pix                   : pixel stream (master side)
//   busy                  : frame in progress
//   done                  : one-cycle pulse after the last pixel is accepted
//   frame_cnt             : completed frames, wraps
module raster_pattern_gen
  import raster_pkg::*;
#(
  parameter int COORD_W    = 11,
  parameter int PIX_W      = 8,
  parameter int CHK_LOG2   = 3,
  parameter int RESTART_EN = 1,
  parameter int FCNT_W     = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [COORD_W-1:0]  win_w,
  input  logic [COORD_W-1:0]  win_h,
  input  logic [1:0]          mode,
  input  logic [PIX_W-1:0]    fill,
  input  logic                border_en,
  raster_pattern_gen_if.master pix,
  output logic                busy,
  output logic                done,
  output logic [FCNT_W-1:0]   frame_cnt
);

  state_e             state;
  state_e             state_nx;
  logic [COORD_W-1:0] cfg_w;
  logic [COORD_W-1:0] cfg_h;
  mode_e              cfg_mode;
  logic [PIX_W-1:0]   cfg_fill;
  logic               cfg_border_en;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               last;
  logic               accept_start;
  logic               xfer;
  logic [COORD_W-1:0] w_max;
  logic [COORD_W-1:0] h_max;
  logic               on_border;
  logic [PIX_W-1:0]   pattern;

  // A zero-size window is never accepted, including as a restart, so a scan
  // always has at least one pixel.
  assign accept_start = start && (win_w != '0) && (win_h != '0) &&
                        ((state == ST_IDLE) ||
                         ((state == ST_SCAN) && (RESTART_EN != 0)));
  assign xfer = (state == ST_SCAN) && pix.pix_ready;

  // NOTE: config registers are reset rather than left undefined so pixel and
  // border are well-defined straight out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cfg_w         <= '0;
      cfg_h         <= '0;
      cfg_mode      <= MODE_FILL;
      cfg_fill      <= '0;
      cfg_border_en <= 1'b0;
    end else if (accept_start) begin
      cfg_w         <= win_w;
      cfg_h         <= win_h;
      cfg_mode      <= mode_e'(mode);
      cfg_fill      <= fill;
      cfg_border_en <= border_en;
    end
  end

  // A restart clears the counter and suppresses the simultaneous transfer.
  raster_xy_counter #(.COORD_W(COORD_W)) u_xy (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (xfer && !accept_start),
    .clear   (accept_start),
    .w       (cfg_w),
    .h       (cfg_h),
    .x       (x),
    .y       (y),
    .last    (last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    // NOTE: default first so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    case (state)
      ST_IDLE: if (accept_start) state_nx = ST_SCAN;
      ST_SCAN: begin
        if (accept_start)      state_nx = ST_SCAN;
        else if (xfer && last) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               frame_cnt <= '0;
    else if (state == ST_DONE)  frame_cnt <= frame_cnt + FCNT_W'(1);
  end

  assign busy = (state == ST_SCAN);
  assign done = (state == ST_DONE);

  assign w_max     = cfg_w - COORD_W'(1);
  assign h_max     = cfg_h - COORD_W'(1);
  assign on_border = (x == '0) || (y == '0) || (x == w_max) || (y == h_max);

  always_comb begin
    pattern = cfg_fill;
    case (cfg_mode)
      MODE_FILL:    pattern = cfg_fill;
      MODE_HGRAD:   pattern = x[PIX_W-1:0];
      MODE_VGRAD:   pattern = y[PIX_W-1:0];
      MODE_CHECKER: pattern = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? ~cfg_fill : cfg_fill;
      default:      pattern = cfg_fill;
    endcase
  end

  assign pix.pix_valid = busy;
  assign pix.x         = x;
  assign pix.y         = y;
  assign pix.border    = on_border;
  assign pix.pixel     = (cfg_border_en && on_border) ? '1 : pattern;

endmodule

// File: tb/tb_raster_pattern_gen.sv
// Self-checking bench for raster_pattern_gen. DUT A uses default parameters;
// DUT B has restart disabled and a 2-bit frame counter. Expected pixels come
// from a reference model pushed to a scoreboard queue when a frame is started.
module tb_raster_pattern_gen;
  import raster_pkg::*;

  localparam int CW = 11;
  localparam int PW = 8;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [PW-1:0] pixel;
    logic          border;
  } pix_t;

  logic          clock;
  logic          reset_n;
  logic          start_a, start_b;
  logic [CW-1:0] win_w, win_h;
  logic [1:0]    mode;
  logic [PW-1:0] fill;
  logic          border_en;
  logic          busy_a, done_a, busy_b, done_b;
  logic [15:0]   fcnt_a;
  logic [1:0]    fcnt_b;

  raster_pattern_gen_if #(.COORD_W(CW), .PIX_W(PW)) pa ();
  raster_pattern_gen_if #(.COORD_W(CW), .PIX_W(PW)) pb ();

  raster_pattern_gen dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a),
    .win_w(win_w), .win_h(win_h), .mode(mode), .fill(fill),
    .border_en(border_en), .pix(pa), .busy(busy_a), .done(done_a),
    .frame_cnt(fcnt_a)
  );

  raster_pattern_gen #(.RESTART_EN(0), .FCNT_W(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b),
    .win_w(win_w), .win_h(win_h), .mode(mode), .fill(fill),
    .border_en(border_en), .pix(pb), .busy(busy_b), .done(done_b),
    .frame_cnt(fcnt_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   errors = 0;
  int   checks = 0;
  int   exp_fcnt_a = 0;
  int   exp_fcnt_b = 0;
  pix_t sb_q[$];

  // sel chooses which DUT the shared tasks drive and observe.
  logic sel;
  pix_t obs;
  logic obs_valid, obs_busy, obs_done;

  always_comb begin
    if (sel) begin
      obs       = {pb.x, pb.y, pb.pixel, pb.border};
      obs_valid = pb.pix_valid;
      obs_busy  = busy_b;
      obs_done  = done_b;
    end else begin
      obs       = {pa.x, pa.y, pa.pixel, pa.border};
      obs_valid = pa.pix_valid;
      obs_busy  = busy_a;
      obs_done  = done_a;
    end
  end

  function automatic pix_t model(input int px, input int py, input int w,
                                 input int h, input logic [1:0] m,
                                 input logic [7:0] f, input logic be);
    pix_t p;
    logic bd;
    logic [7:0] v;
    bd = (px == 0) || (py == 0) || (px == w - 1) || (py == h - 1);
    case (m)
      2'd0:    v = f;
      2'd1:    v = px[7:0];
      2'd2:    v = py[7:0];
      default: v = (px[3] ^ py[3]) ? ~f : f;
    endcase
    if (be && bd) v = 8'hFF;
    p.x = px[CW-1:0];
    p.y = py[CW-1:0];
    p.pixel = v;
    p.border = bd;
    return p;
  endfunction

  task automatic push_frame(input int w, input int h, input logic [1:0] m,
                            input logic [7:0] f, input logic be);
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++)
        sb_q.push_back(model(xx, yy, w, h, m, f, be));
  endtask

  task automatic set_ready(input logic r);
    if (sel) pb.pix_ready = r;
    else     pa.pix_ready = r;
  endtask

  task automatic set_start(input logic s);
    if (sel) start_b = s;
    else     start_a = s;
  endtask

  // Called at a negedge; returns at the negedge of the first SCAN cycle.
  task automatic launch(input int w, input int h, input logic [1:0] m,
                        input logic [7:0] f, input logic be);
    win_w = w[CW-1:0];
    win_h = h[CW-1:0];
    mode = m;
    fill = f;
    border_en = be;
    set_ready(1'b1);
    set_start(1'b1);
    @(negedge clock);
    set_start(1'b0);
  endtask

  task automatic xfer_cycles(input int n, input string tag);
    pix_t e;
    for (int i = 0; i < n; i++) begin
      set_ready(1'b1);
      checks++;
      if (obs_valid !== 1'b1 || obs_done !== 1'b0) begin
        errors++;
        $display("FAIL %s valid/done: got valid=%b done=%b, required 1/0", tag, obs_valid, obs_done);
      end
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL %s scoreboard: got extra pixel (%0d,%0d), required none", tag, obs.x, obs.y);
      end else begin
        e = sb_q.pop_front();
        if (obs !== e) begin
          errors++;
          $display("FAIL %s pixel: got (x=%0d y=%0d pix=%h b=%b) required (x=%0d y=%0d pix=%h b=%b)",
                   tag, obs.x, obs.y, obs.pixel, obs.border, e.x, e.y, e.pixel, e.border);
        end
      end
      @(negedge clock);
    end
  endtask

  // Consumes the rest of a frame; cycle 1 is the current negedge.
  task automatic collect(input int max_cyc, input bit toggle, input string tag,
                         output int done_at, output int n_xfer);
    logic rdy;
    bit   stalled;
    pix_t held;
    pix_t e;
    rdy = 1'b1;
    stalled = 0;
    held = '0;
    done_at = -1;
    n_xfer = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      set_ready(rdy);
      if (stalled) begin
        checks++;
        if (obs !== held) begin
          errors++;
          $display("FAIL %s stall: got (x=%0d y=%0d pix=%h) required held (x=%0d y=%0d pix=%h)",
                   tag, obs.x, obs.y, obs.pixel, held.x, held.y, held.pixel);
        end
      end
      if (obs_done === 1'b1) begin
        done_at = c;
        checks++;
        if (obs_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s valid_in_done: got %b required 0", tag, obs_valid);
        end
        break;
      end
      if (obs_valid && rdy) begin
        n_xfer++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL %s scoreboard: got extra pixel (%0d,%0d), required none", tag, obs.x, obs.y);
        end else begin
          e = sb_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL %s pixel: got (x=%0d y=%0d pix=%h b=%b) required (x=%0d y=%0d pix=%h b=%b)",
                     tag, obs.x, obs.y, obs.pixel, obs.border, e.x, e.y, e.pixel, e.border);
          end
        end
      end
      stalled = obs_valid && !rdy;
      held = obs;
      if (toggle) rdy = ~rdy;
      @(negedge clock);
    end
    checks++;
    if (done_at < 0) begin
      errors++;
      $display("FAIL %s timeout: got no done in %0d cycles, required done", tag, max_cyc);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s leftover: got %0d pixels unsent, required 0", tag, sb_q.size());
    end
  endtask

  task automatic check_fcnt_a(input string tag);
    @(negedge clock);
    checks++;
    if (fcnt_a !== exp_fcnt_a[15:0]) begin
      errors++;
      $display("FAIL %s frame_cnt: got %0d required %0d", tag, fcnt_a, exp_fcnt_a);
    end
  endtask

  task automatic test_reset;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if (obs_valid !== 1'b0 || obs_busy !== 1'b0 || obs_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl dut%0d: got valid=%b busy=%b done=%b required 0/0/0", s, obs_valid, obs_busy, obs_done);
      end
      checks++;
      // Zero config: FILL of 0, and (0,0) is on the border.
      if (obs !== pix_t'({11'd0, 11'd0, 8'h00, 1'b1})) begin
        errors++;
        $display("FAIL reset_pix dut%0d: got (x=%0d y=%0d pix=%h b=%b) required (0,0,00,1)",
                 s, obs.x, obs.y, obs.pixel, obs.border);
      end
    end
    checks++;
    if (fcnt_a !== 16'd0 || fcnt_b !== 2'd0) begin
      errors++;
      $display("FAIL reset_fcnt: got a=%0d b=%0d required 0/0", fcnt_a, fcnt_b);
    end
    sel = 1'b0;
  endtask

  task automatic test_fill_border;
    int d, n;
    sel = 1'b0;
    push_frame(4, 3, 2'd0, 8'h40, 1'b1);
    launch(4, 3, 2'd0, 8'h40, 1'b1);
    collect(100, 1'b0, "fill_border", d, n);
    // Start cycle is cycle 0: 12 pixels in cycles 1..12, done in cycle 13.
    checks++;
    if (d !== 13 || n !== 12) begin
      errors++;
      $display("FAIL fill_border timing: got done_at=%0d xfers=%0d required 13/12", d, n);
    end
    exp_fcnt_a++;
    check_fcnt_a("fill_border");
  endtask

  task automatic test_backpressure;
    int d, n;
    sel = 1'b0;
    push_frame(4, 3, 2'd0, 8'h40, 1'b1);
    launch(4, 3, 2'd0, 8'h40, 1'b1);
    collect(100, 1'b1, "backpressure", d, n);
    checks++;
    if (d !== 24 || n !== 12) begin
      errors++;
      $display("FAIL backpressure timing: got done_at=%0d xfers=%0d required 24/12", d, n);
    end
    exp_fcnt_a++;
    check_fcnt_a("backpressure");
  endtask

  task automatic test_patterns;
    int d, n;
    int w[3];
    int h[3];
    logic [1:0] m[3];
    logic [7:0] f[3];
    logic be[3];
    w = '{5, 3, 16}; h = '{3, 4, 16};
    m = '{2'd1, 2'd2, 2'd3}; f = '{8'h00, 8'h5A, 8'h00};
    be = '{1'b0, 1'b1, 1'b0};
    sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_frame(w[i], h[i], m[i], f[i], be[i]);
      launch(w[i], h[i], m[i], f[i], be[i]);
      // Config inputs are scrambled mid-frame; they must have no effect.
      win_w = 11'd7; win_h = 11'd9; mode = ~m[i]; fill = 8'hC3; border_en = ~be[i];
      collect(400, 1'b0, "pattern", d, n);
      checks++;
      if (d !== w[i] * h[i] + 1) begin
        errors++;
        $display("FAIL pattern%0d timing: got done_at=%0d required %0d", i, d, w[i] * h[i] + 1);
      end
      exp_fcnt_a++;
      check_fcnt_a("pattern");
    end
  endtask

  task automatic test_restart;
    int d, n;
    sel = 1'b0;
    push_frame(4, 3, 2'd0, 8'h40, 1'b1);
    launch(4, 3, 2'd0, 8'h40, 1'b1);
    xfer_cycles(4, "restart_pre");
    checks++;
    if (obs.x !== 11'd0 || obs.y !== 11'd1) begin
      errors++;
      $display("FAIL restart 5th_pixel: got (%0d,%0d) required (0,1)", obs.x, obs.y);
    end
    win_w = 11'd4; win_h = 11'd3; mode = 2'd1; fill = 8'h11; border_en = 1'b0;
    set_ready(1'b1);
    set_start(1'b1);
    @(negedge clock);
    set_start(1'b0);
    checks++;
    if (obs_valid !== 1'b1 || obs_done !== 1'b0 || obs.x !== 11'd0 || obs.y !== 11'd0) begin
      errors++;
      $display("FAIL restart origin: got valid=%b done=%b (%0d,%0d) required 1/0 (0,0)",
               obs_valid, obs_done, obs.x, obs.y);
    end
    sb_q.delete();
    push_frame(4, 3, 2'd1, 8'h11, 1'b0);
    collect(100, 1'b0, "restart", d, n);
    checks++;
    if (d !== 13 || n !== 12) begin
      errors++;
      $display("FAIL restart timing: got done_at=%0d xfers=%0d required 13/12", d, n);
    end
    exp_fcnt_a++;
    check_fcnt_a("restart");
  endtask

  task automatic test_no_restart;
    int d, n;
    sel = 1'b1;
    sb_q.delete();
    push_frame(4, 3, 2'd0, 8'h40, 1'b1);
    launch(4, 3, 2'd0, 8'h40, 1'b1);
    xfer_cycles(4, "norestart_pre");
    win_w = 11'd2; win_h = 11'd2; mode = 2'd1; fill = 8'h11; border_en = 1'b0;
    set_start(1'b1);
    xfer_cycles(1, "norestart_start");
    set_start(1'b0);
    collect(100, 1'b0, "norestart", d, n);
    checks++;
    if (d !== 8 || n !== 7) begin
      errors++;
      $display("FAIL norestart timing: got done_at=%0d xfers=%0d required 8/7", d, n);
    end
    @(negedge clock);
    exp_fcnt_b = (exp_fcnt_b + 1) % 4;
    checks++;
    if (fcnt_b !== exp_fcnt_b[1:0]) begin
      errors++;
      $display("FAIL norestart frame_cnt: got %0d required %0d", fcnt_b, exp_fcnt_b);
    end
    sel = 1'b0;
  endtask

  task automatic test_zero_dim;
    sel = 1'b0;
    launch(0, 3, 2'd0, 8'h40, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_valid !== 1'b0 || obs_busy !== 1'b0) begin
        errors++;
        $display("FAIL zero_w: got valid=%b busy=%b required 0/0", obs_valid, obs_busy);
      end
      @(negedge clock);
    end
    launch(4, 0, 2'd0, 8'h40, 1'b0);
    checks++;
    if (obs_valid !== 1'b0 || obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_h: got valid=%b busy=%b required 0/0", obs_valid, obs_busy);
    end
    check_fcnt_a("zero_dim");
  endtask

  task automatic test_reset_mid_scan;
    int d, n;
    sel = 1'b0;
    sb_q.delete();
    push_frame(4, 3, 2'd0, 8'h40, 1'b1);
    launch(4, 3, 2'd0, 8'h40, 1'b1);
    xfer_cycles(3, "midreset_pre");
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs_valid !== 1'b0 || obs_busy !== 1'b0 || obs_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset ctrl: got valid=%b busy=%b done=%b required 0/0/0", obs_valid, obs_busy, obs_done);
    end
    checks++;
    if (fcnt_a !== 16'd0 || fcnt_b !== 2'd0) begin
      errors++;
      $display("FAIL midreset fcnt: got a=%0d b=%0d required 0/0", fcnt_a, fcnt_b);
    end
    @(negedge clock);
    reset_n = 1'b1;
    exp_fcnt_a = 0;
    exp_fcnt_b = 0;
    sb_q.delete();
    push_frame(2, 2, 2'd2, 8'h00, 1'b0);
    launch(2, 2, 2'd2, 8'h00, 1'b0);
    collect(50, 1'b0, "midreset_fresh", d, n);
    checks++;
    if (d !== 5) begin
      errors++;
      $display("FAIL midreset_fresh timing: got done_at=%0d required 5", d);
    end
    exp_fcnt_a++;
    check_fcnt_a("midreset_fresh");
  endtask

  task automatic test_frame_wrap;
    int d, n;
    sel = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push_frame(1, 1, 2'd1, 8'h00, 1'b0);
      launch(1, 1, 2'd1, 8'h00, 1'b0);
      collect(10, 1'b0, "wrap", d, n);
      @(negedge clock);
      exp_fcnt_b = (exp_fcnt_b + 1) % 4;
      checks++;
      if (d !== 2 || fcnt_b !== exp_fcnt_b[1:0]) begin
        errors++;
        $display("FAIL wrap frame%0d: got done_at=%0d frame_cnt=%0d required 2/%0d", k, d, fcnt_b, exp_fcnt_b);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    sel = 1'b0;
    reset_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    win_w = '0;
    win_h = '0;
    mode = 2'd0;
    fill = '0;
    border_en = 1'b0;
    pa.pix_ready = 1'b0;
    pb.pix_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    test_reset();
    reset_n = 1'b1;
    @(negedge clock);
    test_fill_border();
    test_backpressure();
    test_patterns();
    test_restart();
    test_no_restart();
    test_zero_dim();
    test_reset_mid_scan();
    test_frame_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
